uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; the receive-side counterpart of the UART TX path.
//  - Shares the 2-bit baud select encoding with the TX baud generator, so TX and RX run at one selected rate.
//  - Oversamples rx at 16x, checks the start bit, shifts in 8 data bits LSB first and checks the stop bit.
//  - Presents each byte with a one-cycle valid strobe; there is no back-pressure.
// PARAMETERS
//  - CLK_FREQ    50000000  system clock frequency in Hz
//  - OVERSAMPLE  16        sample ticks per bit; fixed at 16, and the mid-bit sample is at tick 8
// PORTS
//  - clock       in   1  system clock, rising edge
//  - rst         in   1  asynchronous, active-high reset
//  - baud_rate   in   2  00=2400, 01=4800, 10=9600, 11=19200
//  - rx          in   1  serial line, idle high, asynchronous to clock
//  - rx_data     out  8  last received byte
//  - rx_valid    out  1  one-cycle strobe: good frame, rx_data updated
//  - frame_err   out  1  one-cycle strobe: stop bit sampled low
//  - rx_busy     out  1  high from start detection until the stop sample
//  - parity_err  out  1  one-cycle strobe; port exists only with UART_RX_PARITY_EN
// BEHAVIOUR
//  - Reset: rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, parity_err=0, state=IDLE.
//    Both synchronizer flops reset to 1.
//  - rx passes through a 2-flop synchronizer; edge detection uses the synchronized value only.
//  - Tick divisor = CLK_FREQ/(baud*16), truncated.
//    At 50 MHz: 1302/651/325/162 clocks.
//  - baud_rate is latched at start detection and held for the whole frame.
//    A change mid-frame takes effect on the next frame.
//  - Tick counter restarts at 0 on start detection, so the phase is aligned to the falling edge.
//  - FSM states and transitions:
//    - IDLE: a synced 1->0 edge goes to START; sample count=0.
//    - START: after 8 ticks, sample. If 0, go to DATA. If 1, it is a false start: return to IDLE with no strobe.
//    - DATA: every 16 ticks, shift the sample into bit[n], LSB first. After bit 7, go to STOP
//      (or to PARITY if the macro is defined).
//    - PARITY (macro only): after 16 ticks, sample the parity bit, then go to STOP.
//    - STOP: after 16 ticks, sample.
//      - 1: rx_data<=shift, rx_valid=1 for one clock.
//      - 0: frame_err=1 for one clock; rx_data is unchanged.
//      - In both cases, go to IDLE.
//  - After a framing error the line may stay low. No new frame starts until a fresh 1->0 edge is seen.
//  - Latency: rx_valid rises 2 sync clocks + 9.5 bit periods after the line falls
//    (10.5 with parity). At 9600, that is about 49400 clocks.
//  - Back-to-back frames: the next start edge can be detected in the clock after the stop sample.
//  - rst mid-frame: immediate return to IDLE. No strobe; the partial byte is discarded.
//  - rx_valid and frame_err are never asserted together.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    - One even-parity bit is inserted between bit 7 and the stop bit.
//    - A mismatch pulses parity_err in the same cycle as the stop-bit decision.
//    - On a parity mismatch, rx_valid is suppressed and rx_data is unchanged.
//    - If the stop bit is also bad, frame_err fires as well.
//  - UART_RX_PARITY_EN undefined: 8N1 only; no PARITY state and no parity_err port.
// STRUCTURE
//  - Shared package uart_pkg:
//    - baud select codes BAUD_2400..BAUD_19200 and the baud lookup function
//    - OVERSAMPLE=16
//    - FSM state encoding IDLE/START/DATA/PARITY/STOP, shared with the TX FSM
//  - Sub-module uart_rx_tick_gen:
//    - produces the 16x tick from CLK_FREQ and the latched baud_rate
//    - has a synchronous restart input that top-level start detection drives
//  - uart_rx top: synchronizer, FSM, bit/tick counters, shift register, output strobes.
// TESTING
//  - T1: rst held for 10 ns then released, rx=1 -> all outputs 0, rx_busy=0, with no strobes for 100 us.
//  - T2: baud=10 (9600, 5200 clocks/bit); send 0xA5 as 8N1 -> exactly one rx_valid pulse with rx_data=8'hA5.
//    frame_err stays 0.
//  - T3: baud=10; drive rx low for 2000 clocks (less than 2600), then high -> rx_busy pulses, no rx_valid, no frame_err.
//  - T4: baud=11; send 0x3C with stop bit 0 -> one frame_err pulse, no rx_valid, rx_data keeps its previous value.
//  - T5: baud=00; send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses with data 00 then FF.
//  - T6: baud=01; assert rst at bit 4 of a frame, release it, then send 0x5A -> no strobe from the aborted frame;
//    next rx_valid shows 5A. With the macro: a wrong parity bit -> parity_err pulses and rx_valid does not.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, oversampling ratio, FSM states.
// Used by both the TX and RX paths so they agree on rate encoding.
// No logic, no latency, no flow control.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_sel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic int baud_hz(input logic [1:0] sel);
        int hz;
        case (sel)
            BAUD_2400:  hz = 2400;
            BAUD_4800:  hz = 4800;
            BAUD_9600:  hz = 9600;
            default:    hz = 19200;
        endcase
        return hz;
    endfunction

    // Clocks per 16x sample tick, truncated.
    function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
        return clk_freq / (baud_hz(sel) * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling tick generator for the UART receiver.
// Latency: first tick one divisor period after restart (registered tick).
// Backpressure: none; free-running, restart realigns phase.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       restart,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    localparam int MAX_DIV = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int CW      = $clog2(MAX_DIV + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div_m1;

    assign div_m1 = CW'(baud_div(CLK_FREQ, baud_sel) - 1);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == div_m1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling; even parity with UART_RX_PARITY_EN.
// Latency: rx_valid ~2 sync clocks + 9.5 bit periods after the start edge (10.5 with parity).
// Backpressure: none; rx_valid/frame_err are single-cycle strobes that must be taken.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        start_edge;
    logic        restart;
    logic        tick;
    uart_state_t state;
    logic [1:0]  baud_lat;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
`ifdef UART_RX_PARITY_EN
    logic        par_bit;
`endif

    // Line is idle-high, so the synchronizer resets to 1 to avoid a phantom edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign restart    = (state == IDLE) && start_edge;

    uart_rx_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clock    (clock),
        .rst      (rst),
        .restart  (restart),
        .baud_sel (baud_lat),
        .tick     (tick)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_lat  <= 2'b00;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        baud_lat <= baud_rate;
                        tick_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            if (!rx_sync) begin
                                state <= DATA;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            shift   <= {rx_sync, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            par_bit <= rx_sync;
                            state   <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            state     <= IDLE;
                            rx_busy   <= 1'b0;
                            frame_err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data bits plus parity bit must XOR to zero.
                            parity_err <= (^shift) ^ par_bit;
                            if (rx_sync && ((^shift) == par_bit)) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end
`else
                            if (rx_sync) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
